uart_rx_sequencer: RTL

UART receive-path sequencer that frames the glitch-filtered serial input into characters. It runs from the system clock, advances on a 16x-oversample baud enable, detects and qualifies start bits, and samples data, parity and stop bits at mid-bit. It delivers each received word with parity, framing and break status to the RX FIFO and line-status logic. It sits between the RX input filter output and the RX FIFO write port.

---
 rtl/uart_rx_sequencer_if.sv | 11 +
 rtl/uart_rx_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_sequencer_if.sv
// Received-word bundle from the UART RX sequencer to the RX FIFO and line-status logic.
interface uart_rx_sequencer_if;
  logic [7:0] DOUT;
  logic       PE;
  logic       FE;
  logic       BI;
  logic       RXFINISHED;

  modport master (output DOUT, PE, FE, BI, RXFINISHED);
  modport slave  (input  DOUT, PE, FE, BI, RXFINISHED);
endinterface

// File: rtl/uart_rx_sequencer.sv
// UART receive framing: start qualification, mid-bit sampling of data/parity/stop,
// and registered delivery of each word with parity, framing and break status.
module uart_rx_sequencer (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       RXCLK,
  input  logic                       CLR,
  input  logic                       RXD,
  input  logic [1:0]                 WLS,
  input  logic                       STB,
  input  logic                       PEN,
  input  logic                       EPS,
  input  logic                       SP,
  uart_rx_sequencer_if.master        rx
);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, MWAIT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  bcnt_q, bcnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        acc_q, acc_d;
  logic        rpar_q, rpar_d;
  logic [7:0]  dout_q, dout_d;
  logic        pe_q, pe_d;
  logic        fe_q, fe_d;
  logic        bi_q, bi_d;
  logic        fin_q, fin_d;

  // Only the first stop bit is ever checked, so the stop-bit count has no role here.
  logic        unused_stb;
  assign unused_stb = STB;

  function automatic logic [2:0] last_bit(input logic [1:0] wls);
    return {1'b0, wls} + 3'd4;
  endfunction

  function automatic logic expected_parity(input logic sp, input logic eps, input logic acc);
    if (sp) return ~eps;
    return eps ? acc : ~acc;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    rpar_d  = rpar_q;
    dout_d  = dout_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    bi_d    = bi_q;
    fin_d   = 1'b0;

    if (CLR) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
      bcnt_d  = 3'd0;
    end else if (RXCLK) begin
      case (state_q)
        IDLE: begin
          if (!RXD) begin
            state_d = START;
            cnt_d   = 4'd0;
          end
        end
        START: begin
          if (cnt_q != 4'd7) begin
            cnt_d = cnt_q + 4'd1;
          end else if (!RXD) begin
            state_d = DATA;
            cnt_d   = 4'd0;
            bcnt_d  = 3'd0;
            shift_d = 8'h00;
            acc_d   = 1'b0;
          end else begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end
        end
        DATA: begin
          if (cnt_q != 4'd15) begin
            cnt_d = cnt_q + 4'd1;
          end else begin
            shift_d[bcnt_q] = RXD;
            acc_d           = acc_q ^ RXD;
            cnt_d           = 4'd0;
            // bcnt wraps, so a word length changed mid-frame still terminates.
            if (bcnt_q == last_bit(WLS)) begin
              state_d = PEN ? PAR : STOP;
            end else begin
              bcnt_d = bcnt_q + 3'd1;
            end
          end
        end
        PAR: begin
          if (cnt_q != 4'd15) begin
            cnt_d = cnt_q + 4'd1;
          end else begin
            rpar_d  = RXD;
            state_d = STOP;
            cnt_d   = 4'd0;
          end
        end
        STOP: begin
          if (cnt_q != 4'd15) begin
            cnt_d = cnt_q + 4'd1;
          end else begin
            dout_d  = shift_q;
            pe_d    = PEN & (rpar_q != expected_parity(SP, EPS, acc_q));
            fe_d    = ~RXD;
            bi_d    = (shift_q == 8'h00) & (~rpar_q | ~PEN) & ~RXD;
            fin_d   = 1'b1;
            cnt_d   = 4'd0;
            bcnt_d  = 3'd0;
            state_d = RXD ? IDLE : MWAIT;
          end
        end
        MWAIT: begin
          if (RXD) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          bcnt_d  = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      bcnt_q  <= 3'd0;
      dout_q  <= 8'h00;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      bi_q    <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      dout_q  <= dout_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      bi_q    <= bi_d;
      fin_q   <= fin_d;
    end
  end

  // Frame-internal datapath is always rewritten before use, so it carries no reset.
  always_ff @(posedge CLK) begin
    shift_q <= shift_d;
    acc_q   <= acc_d;
    rpar_q  <= rpar_d;
  end

  assign rx.DOUT       = dout_q;
  assign rx.PE         = pe_q;
  assign rx.FE         = fe_q;
  assign rx.BI         = bi_q;
  assign rx.RXFINISHED = fin_q;

endmodule
